m_stage_hs: RTL and testbench
=============================

Name: m_stage_hs

Overview:
- Handshaked, parametrised memory-access stage, placed between execute and writeback.
- Successor to the fixed single-cycle memory stage. Adds:
  - valid/ready flow control
  - a req/gnt/rvalid data-bus protocol with variable latency
  - byte-lane alignment and byte enables for loads and stores
  - sign- or zero-extension of loads
  - misaligned-access and bus-timeout detection
- Produces the writeback value and forwards the writeback control word.

Parameters:
- W_CON_W, 6, width of w_con_in / w_con_out.
- TIMEOUT, 16, max cycles waiting on mem_gnt or mem_rvalid before bus_err; 0 disables the timeout.
- PC_INC, 4, increment added to pc for link writeback.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- alu_result  in  32  effective address / ALU value.
- pc  in  32  instruction pc.
- store_data  in  32  unaligned store source (low bits significant).
- m_con  in  7  [1:0] wb_sel (00 pc+PC_INC, 01 alu, 10 mem, 11 zero); [3:2] rd_size; [5:4] wr_size (00 none, 01 byte, 10 half, 11 word); [6] sign (1 = sign-extend).
- w_con_in  in  W_CON_W  writeback control.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, {alu_result[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- out_valid  out  1  one-cycle result pulse.
- reg_write_data  out  32  writeback value.
- w_con_out  out  W_CON_W  registered w_con_in.
- misaligned  out  1  qualifies out_valid.
- bus_err  out  1  qualifies out_valid.

Behaviour:
- Reset (async): state IDLE.
  - 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, reg_write_data, w_con_out, misaligned, bus_err, timeout counter.
  - Reset mid-transaction abandons the op; no output pulse follows.
- Accept: at the edge where in_valid && in_ready, capture all inputs.
- rd_size != 0 selects a load. A write is ignored when rd_size != 0.
- Misalignment:
  - half with addr[0] = 1 is misaligned.
  - word with addr[1:0] != 0 is misaligned.
  - A misaligned access issues no bus request.
- Non-memory op or misaligned access:
  - next cycle out_valid = 1 and state returns to IDLE (latency 1).
  - misaligned set as applicable; reg_write_data = 0 when misaligned.
- Memory op: state REQ from the cycle after accept.
  - mem_req = 1; mem_we, mem_addr, mem_be, mem_wdata are held stable until mem_gnt is sampled high.
  - Byte enables by size: byte = 1 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
  - mem_wdata = store_data replicated into the selected lane.
- On mem_gnt in REQ: mem_req drops the same edge.
  - Store: out_valid pulses next cycle, then IDLE.
  - Load: go to WAIT.
- WAIT: mem_rvalid (never in the same cycle as gnt) → next cycle out_valid = 1 and reg_write_data = extracted load.
- Load extraction: shift mem_rdata right by 8*addr[1:0], then truncate to size. Extend per the sign bit:
  - sign = 1 sign-extends.
  - sign = 0 zero-extends.
- Writeback value:
  - wb_sel 00: pc + PC_INC, modulo 2^32.
  - wb_sel 01: alu_result.
  - wb_sel 10: load data, or 0 for a store/non-load.
  - wb_sel 11: 0.
- Timeout:
  - Counter clears on entering REQ or WAIT and increments each cycle there.
  - When it reaches TIMEOUT without gnt/rvalid: out_valid = 1, bus_err = 1, reg_write_data = 0, mem_req drops, state IDLE.
  - gnt/rvalid arriving in the same cycle the count hits TIMEOUT wins over the timeout.
- w_con_out updates with every out_valid pulse.
- Between pulses, out_valid = 0 and the data outputs hold their last values.
- in_ready is low in REQ, WAIT and the output cycle. Back-to-back non-memory ops sustain 1 op per 2 cycles.

Test Plan:
- ALU op: wb_sel 01, alu_result 0x1234_5678, w_con_in 0x2A → one cycle later out_valid = 1, reg_write_data 0x1234_5678, w_con_out 0x2A, no mem_req.
- Signed byte load: addr 0x103, rdata 0x80FF_0000, sign = 1 → mem_addr 0x100, mem_be 1000, result 0xFFFF_FF80; sign = 0 → 0x0000_0080.
- Half store at 0x202, store_data 0xABCD, gnt withheld 3 cycles → mem_req and mem_be 1100 and mem_wdata 0xABCD_ABCD stable throughout; out_valid the cycle after gnt.
- Misaligned word load at 0x301 → no mem_req; out_valid with misaligned = 1, reg_write_data 0.
- TIMEOUT = 4, load, gnt but no rvalid → bus_err pulse with out_valid after 4 WAIT cycles; next op accepted normally.
- rst_n low while in WAIT → immediate IDLE, all outputs 0; a later rvalid is ignored and produces no out_valid.

Source files
------------

// File: rtl/m_stage_hs.sv
// Handshaked memory-access stage between execute and writeback: req/gnt/rvalid bus master
// with byte-lane alignment, load extension, misalignment and bus-timeout reporting.
module m_stage_hs #(
    parameter int W_CON_W = 6,
    parameter int TIMEOUT = 16,
    parameter int PC_INC  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        pc,
    input  logic [31:0]        store_data,
    input  logic [6:0]         m_con,
    input  logic [W_CON_W-1:0] w_con_in,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    output logic               out_valid,
    output logic [31:0]        reg_write_data,
    output logic [W_CON_W-1:0] w_con_out,
    output logic               misaligned,
    output logic               bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_reg;
    logic [31:0]        pc_reg;
    logic [1:0]         wb_sel_reg;
    logic [1:0]         rd_size_reg;
    logic               sign_reg;
    logic [W_CON_W-1:0] w_con_reg;

    logic               in_load;
    logic               in_store;
    logic [1:0]         in_size;
    logic               in_mis;
    logic               timeout_hit;
    logic [31:0]        fin_load;
    logic [31:0]        fin_data;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b10:   is_misaligned = lo[0];
            2'b11:   is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   byte_enable = 4'b0001 << lo;
            2'b10:   byte_enable = 4'b0011 << lo;
            2'b11:   byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    endfunction

    // Replicating the low bytes puts the store value on every lane, so the byte
    // enables alone select where it lands.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b01:   lane_data = {4{sd[7:0]}};
            2'b10:   lane_data = {2{sd[15:0]}};
            default: lane_data = sd;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic sign,
                                                 input logic [1:0] lo, input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {lo, 3'b000};
        case (size)
            2'b01:   extract_load = {{24{sign & shifted[7]}}, shifted[7:0]};
            2'b10:   extract_load = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: extract_load = shifted;
        endcase
    endfunction

    function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] pcv,
                                             input logic [31:0] alu, input logic [31:0] ld);
        case (sel)
            2'b00:   wb_value = pcv + 32'(PC_INC);
            2'b01:   wb_value = alu;
            2'b10:   wb_value = ld;
            default: wb_value = 32'd0;
        endcase
    endfunction

    assign in_ready = (state == IDLE);

    // A load takes priority: its write-size field is ignored.
    assign in_load  = (m_con[3:2] != 2'b00);
    assign in_store = !in_load && (m_con[5:4] != 2'b00);
    assign in_size  = in_load ? m_con[3:2] : m_con[5:4];
    assign in_mis   = (in_load || in_store) && is_misaligned(in_size, alu_result[1:0]);

    assign fin_load = extract_load(rd_size_reg, sign_reg, addr_reg[1:0], mem_rdata);
    assign fin_data = wb_value(wb_sel_reg, pc_reg, addr_reg, (state == WAIT) ? fin_load : 32'd0);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_reg       <= '0;
            pc_reg         <= '0;
            wb_sel_reg     <= '0;
            rd_size_reg    <= '0;
            sign_reg       <= 1'b0;
            w_con_reg      <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            out_valid      <= 1'b0;
            reg_write_data <= '0;
            w_con_out      <= '0;
            misaligned     <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        addr_reg    <= alu_result;
                        pc_reg      <= pc;
                        wb_sel_reg  <= m_con[1:0];
                        rd_size_reg <= m_con[3:2];
                        sign_reg    <= m_con[6];
                        w_con_reg   <= w_con_in;
                        if ((in_load || in_store) && !in_mis) begin
                            mem_req   <= 1'b1;
                            mem_we    <= in_store;
                            mem_addr  <= {alu_result[31:2], 2'b00};
                            mem_be    <= byte_enable(in_size, alu_result[1:0]);
                            mem_wdata <= in_store ? lane_data(in_size, store_data) : 32'd0;
                            cnt       <= '0;
                            state     <= REQ;
                        end else begin
                            out_valid      <= 1'b1;
                            misaligned     <= in_mis;
                            bus_err        <= 1'b0;
                            w_con_out      <= w_con_in;
                            reg_write_data <= in_mis ? 32'd0
                                                     : wb_value(m_con[1:0], pc, alu_result, 32'd0);
                            state          <= OUT;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        if (mem_we) begin
                            out_valid      <= 1'b1;
                            misaligned     <= 1'b0;
                            bus_err        <= 1'b0;
                            w_con_out      <= w_con_reg;
                            reg_write_data <= fin_data;
                            state          <= OUT;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req        <= 1'b0;
                        out_valid      <= 1'b1;
                        misaligned     <= 1'b0;
                        bus_err        <= 1'b1;
                        w_con_out      <= w_con_reg;
                        reg_write_data <= 32'd0;
                        state          <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        out_valid      <= 1'b1;
                        misaligned     <= 1'b0;
                        bus_err        <= 1'b0;
                        w_con_out      <= w_con_reg;
                        reg_write_data <= fin_data;
                        state          <= OUT;
                    end else if (timeout_hit) begin
                        out_valid      <= 1'b1;
                        misaligned     <= 1'b0;
                        bus_err        <= 1'b1;
                        w_con_out      <= w_con_reg;
                        reg_write_data <= 32'd0;
                        state          <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_stage_hs.sv
// Directed bench for m_stage_hs (TIMEOUT = 4): one task per scenario, inline checks.
module tb_m_stage_hs;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] store_data;
    logic [6:0]  m_con;
    logic [5:0]  w_con_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] reg_write_data;
    logic [5:0]  w_con_out;
    logic        misaligned;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    m_stage_hs #(.W_CON_W(6), .TIMEOUT(4), .PC_INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .pc(pc), .store_data(store_data), .m_con(m_con),
        .w_con_in(w_con_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .reg_write_data(reg_write_data),
        .w_con_out(w_con_out), .misaligned(misaligned), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [6:0] mc, input logic [31:0] alu, input logic [31:0] pcv,
                            input logic [31:0] sd, input logic [5:0] wc);
        m_con = mc; alu_result = alu; pc = pcv; store_data = sd; w_con_in = wc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; pc = '0; store_data = '0;
        m_con = '0; w_con_in = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, reg_write_data,
             w_con_out, misaligned, bus_err} !== 111'd0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h ov=%b rwd=%h wc=%h mis=%b be=%b, want all 0",
                     mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, reg_write_data,
                     w_con_out, misaligned, bus_err);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
        $display("reset: checked idle outputs");
    endtask

    task automatic test_alu();
        drive_op({1'b0, 2'b00, 2'b00, 2'b01}, 32'h1234_5678, 32'h1000, 32'h0, 6'h2A);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL alu_out_valid: got %b want 1", out_valid); end
        total++;
        if (reg_write_data !== 32'h1234_5678) begin bad++; $display("FAIL alu_data: got %h want 12345678", reg_write_data); end
        total++;
        if (w_con_out !== 6'h2A) begin bad++; $display("FAIL alu_wcon: got %h want 2a", w_con_out); end
        total++;
        if (mem_req !== 1'b0 || misaligned !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL alu_flags: got req=%b mis=%b rdy=%b want 0 0 0", mem_req, misaligned, in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || reg_write_data !== 32'h1234_5678) begin
            bad++; $display("FAIL alu_after: got ov=%b rdy=%b rwd=%h want 0 1 12345678", out_valid, in_ready, reg_write_data);
        end
        $display("alu: wb_sel=01 result=%h", reg_write_data);
    endtask

    task automatic test_back_to_back();
        m_con = {1'b0, 2'b00, 2'b00, 2'b00}; pc = 32'hFFFF_FFFE; alu_result = 32'h55; w_con_in = 6'h11;
        in_valid = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || reg_write_data !== 32'h0000_0002 || in_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_link: got ov=%b rwd=%h rdy=%b want 1 00000002 0", out_valid, reg_write_data, in_ready);
        end
        m_con = {1'b0, 2'b00, 2'b00, 2'b11}; alu_result = 32'hFFFF; w_con_in = 6'h22;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_gap: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || reg_write_data !== 32'h0 || w_con_out !== 6'h22) begin
            bad++; $display("FAIL b2b_zero: got ov=%b rwd=%h wc=%h want 1 00000000 22", out_valid, reg_write_data, w_con_out);
        end
        tick();
        $display("back_to_back: two ops in four cycles");
    endtask

    task automatic test_load(input logic [6:0] mc, input logic [31:0] alu, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_data);
        drive_op(mc, alu, 32'h0, 32'hFFFF_FFFF, 6'h05);
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || mem_be !== exp_be) begin
            bad++; $display("FAIL load_req: got req=%b we=%b addr=%h be=%b want 1 0 %h %b",
                            mem_req, mem_we, mem_addr, mem_be, exp_addr, exp_be);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        total++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL load_gnt: got req=%b ov=%b want 0 0", mem_req, out_valid);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || reg_write_data !== exp_data || bus_err !== 1'b0 || w_con_out !== 6'h05) begin
            bad++; $display("FAIL load_data: got ov=%b rwd=%h be=%b wc=%h want 1 %h 0 05",
                            out_valid, reg_write_data, bus_err, w_con_out, exp_data);
        end
        tick();
        $display("load: addr=%h rdata=%h result=%h", alu, rdata, reg_write_data);
    endtask

    task automatic test_store(input logic [6:0] mc, input logic [31:0] alu, input logic [31:0] sd,
                              input int stall, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        drive_op(mc, alu, 32'h0, sd, 6'h09);
        for (int i = 0; i <= stall; i++) begin
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr || mem_be !== exp_be ||
                mem_wdata !== exp_wdata || out_valid !== 1'b0) begin
                bad++; $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h be=%b wd=%h ov=%b want 1 1 %h %b %h 0",
                                i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, exp_addr, exp_be, exp_wdata);
            end
            if (i < stall) tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        total++;
        if (out_valid !== 1'b1 || mem_req !== 1'b0 || bus_err !== 1'b0 || reg_write_data !== exp_data) begin
            bad++; $display("FAIL store_done: got ov=%b req=%b berr=%b rwd=%h want 1 0 0 %h",
                            out_valid, mem_req, bus_err, reg_write_data, exp_data);
        end
        tick();
        $display("store: addr=%h be=%b wdata=%h stall=%0d", alu, exp_be, exp_wdata, stall);
    endtask

    task automatic test_misaligned();
        drive_op({1'b0, 2'b00, 2'b11, 2'b01}, 32'h301, 32'h0, 32'h0, 6'h01);
        total++;
        if (out_valid !== 1'b1 || misaligned !== 1'b1 || reg_write_data !== 32'h0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL mis_word: got ov=%b mis=%b rwd=%h req=%b want 1 1 0 0",
                            out_valid, misaligned, reg_write_data, mem_req);
        end
        tick();
        drive_op({1'b0, 2'b10, 2'b00, 2'b01}, 32'h205, 32'h0, 32'h1234, 6'h02);
        total++;
        if (out_valid !== 1'b1 || misaligned !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL mis_half_store: got ov=%b mis=%b req=%b want 1 1 0", out_valid, misaligned, mem_req);
        end
        tick();
        $display("misaligned: word@301 and half store@205 flagged");
    endtask

    task automatic test_timeout();
        drive_op({1'b0, 2'b00, 2'b01, 2'b01}, 32'h100, 32'h0, 32'h0, 6'h07);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL wait_early[%0d]: got ov=%b want 0", i, out_valid); end
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || bus_err !== 1'b1 || reg_write_data !== 32'h0 || w_con_out !== 6'h07) begin
            bad++; $display("FAIL wait_timeout: got ov=%b berr=%b rwd=%h wc=%h want 1 1 0 07",
                            out_valid, bus_err, reg_write_data, w_con_out);
        end
        tick();
        drive_op({1'b0, 2'b00, 2'b00, 2'b01}, 32'hCAFE, 32'h0, 32'h0, 6'h03);
        total++;
        if (out_valid !== 1'b1 || bus_err !== 1'b0 || misaligned !== 1'b0 || reg_write_data !== 32'hCAFE) begin
            bad++; $display("FAIL after_timeout: got ov=%b berr=%b mis=%b rwd=%h want 1 0 0 0000cafe",
                            out_valid, bus_err, misaligned, reg_write_data);
        end
        tick();
        drive_op({1'b0, 2'b11, 2'b00, 2'b01}, 32'h40, 32'h0, 32'h0, 6'h04);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
                bad++; $display("FAIL req_early[%0d]: got req=%b ov=%b want 1 0", i, mem_req, out_valid);
            end
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || bus_err !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL req_timeout: got ov=%b berr=%b req=%b want 1 1 0", out_valid, bus_err, mem_req);
        end
        tick();
        $display("timeout: wait and request timeouts reported");
    endtask

    task automatic test_reset_mid();
        drive_op({1'b1, 2'b00, 2'b01, 2'b10}, 32'h100, 32'h0, 32'h0, 6'h3F);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, reg_write_data,
             w_con_out, misaligned, bus_err} !== 111'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid: got req=%b addr=%h be=%b ov=%b rwd=%h wc=%h rdy=%b want zeros and rdy=1",
                            mem_req, mem_addr, mem_be, out_valid, reg_write_data, w_con_out, in_ready);
        end
        #2;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00FF;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_rvalid: got ov=%b want 0", out_valid); end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid_idle: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        $display("reset_mid: transaction abandoned");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load({1'b1, 2'b00, 2'b01, 2'b10}, 32'h103, 32'h80FF_0000, 32'h100, 4'b1000, 32'hFFFF_FF80);
        test_load({1'b0, 2'b00, 2'b01, 2'b10}, 32'h103, 32'h80FF_0000, 32'h100, 4'b1000, 32'h0000_0080);
        test_load({1'b1, 2'b00, 2'b10, 2'b10}, 32'h102, 32'h8001_1234, 32'h100, 4'b1100, 32'hFFFF_8001);
        test_load({1'b1, 2'b00, 2'b11, 2'b10}, 32'h104, 32'hDEAD_BEEF, 32'h104, 4'b1111, 32'hDEAD_BEEF);
        test_load({1'b1, 2'b00, 2'b01, 2'b01}, 32'h2001, 32'h0000_FF00, 32'h2000, 4'b0010, 32'h0000_2001);
        test_load({1'b0, 2'b11, 2'b01, 2'b10}, 32'h101, 32'h0000_AB00, 32'h100, 4'b0010, 32'h0000_00AB);
        test_store({1'b0, 2'b10, 2'b00, 2'b10}, 32'h202, 32'h0000_ABCD, 3, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0);
        test_store({1'b0, 2'b01, 2'b00, 2'b01}, 32'h13, 32'h0000_005A, 0, 32'h10, 4'b1000, 32'h5A5A_5A5A, 32'h13);
        test_store({1'b0, 2'b11, 2'b00, 2'b11}, 32'h204, 32'h1122_3344, 1, 32'h204, 4'b1111, 32'h1122_3344, 32'h0);
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
